interp_line_scheduler: RTL and testbench
========================================

// Module: interp_line_scheduler
// PURPOSE
//  Frame/line sequencer for the interpolation output path. Issues per-line write grants to the
//  interpolation core, steering lines alternately into the two line AFIFOs (ch1 first, then ch0)
//  that the pixel re-range/AXIS stage drains. Meters the core with a credit counter so the core
//  never runs more than MAX_AHEAD lines ahead of the reader. Closes the frame on rd_done_sig.
// PARAMETERS
//  H_pixel    1280  pixels per line; informational only, checked in simulation
//  V_line     960   lines per output frame; the scheduler issues V_line-1 lines (reader replays last)
//  MAX_AHEAD  2     max lines written but not yet consumed; range 1..15
//  TIMEOUT    2^20  cycles allowed in L_BUSY before watchdog fires (FRAME_TIMEOUT_EN only)
// PORTS
//  Clk              in   1   single clock for all logic
//  aRst_n           in   1   asynchronous active-low reset
//  frame_start_i    in   1   1-cycle pulse; starts a frame, ignored unless state==IDLE
//  line_req_o       out  1   line grant request to core; held high until line_ack_i
//  line_ack_i       in   1   core accepts grant (req&ack = issue)
//  line_sel_o       out  1   target AFIFO for current line: 1=ch1, 0=ch0
//  line_idx_o       out  12  index of current line, 0..V_line-2
//  line_done_i      in   1   1-cycle pulse: core finished writing current line
//  line_consumed_i  in   1   1-cycle pulse: reader consumed one line (its tlast write)
//  rd_done_sig      in   1   high while reader replays the last line
//  frame_busy_o     out  1   high in every state except IDLE
//  frame_done_o     out  1   1-cycle pulse at frame completion
//  credit_o         out  4   current credit count
//  timeout_err_o    out  1   sticky watchdog flag (FRAME_TIMEOUT_EN only)
// BEHAVIOUR
//  Reset: state=IDLE; line_req_o=0; line_sel_o=1; line_idx_o=0; frame_busy_o=0; frame_done_o=0;
//   credit_o=MAX_AHEAD; timeout_err_o=0. All outputs are registered.
//  States: IDLE, ISSUE, L_BUSY, DRAIN_HI, DRAIN_LO.
//  IDLE: on frame_start_i go to ISSUE. Set line_idx=0, line_sel=1, credit=MAX_AHEAD.
//  ISSUE: line_req_o=1 only when credit>0. req&ack: line_req_o drops on next cycle,
//   credit decrements, go to L_BUSY. ack without req is ignored.
//  L_BUSY: wait for line_done_i.
//   - If line_idx==V_line-2, go to DRAIN_HI.
//   - Else line_idx+1, toggle line_sel, go to ISSUE.
//   - line_done_i outside L_BUSY is ignored.
//  DRAIN_HI: wait for rd_done_sig==1, then go to DRAIN_LO.
//  DRAIN_LO: wait for rd_done_sig==0, pulse frame_done_o for 1 cycle, go to IDLE.
//  Credit update, all states except IDLE:
//   - consumed only: +1, saturating at MAX_AHEAD.
//   - issue only: -1.
//   - issue and consumed in the same cycle: credit unchanged.
//   - credit never underflows, because issue requires credit>0.
//  Grant latency: frame_start_i -> line_req_o is 1 cycle. line_done_i -> next line_req_o is
//   1 cycle when credit>0.
//  frame_start_i while busy: dropped, no queueing.
//  Reset mid-frame: immediate return to reset values. The AFIFOs are reset by the same aRst_n.
// CONFIGURATION
//  `define FRAME_TIMEOUT_EN
//  Defined:
//   - 21-bit watchdog counts cycles spent in L_BUSY and clears on each line_done_i.
//   - On reaching TIMEOUT: timeout_err_o=1 (sticky until reset), line_req_o=0, state->IDLE,
//     frame_done_o is NOT pulsed.
//  Not defined:
//   - No counter; timeout_err_o is tied 0.
//   - Scheduler waits in L_BUSY indefinitely.
// TESTING
//  T1 V_line=4, MAX_AHEAD=2, ack next cycle, done 5 cycles after ack, consumed 20 cycles after
//   each done -> 3 grants with line_sel 1,0,1 and line_idx 0,1,2; rd_done_sig hi/lo ->
//   one frame_done_o pulse, then IDLE.
//  T2 MAX_AHEAD=2, line_consumed_i held 0 -> exactly 2 grants; line_req_o stays 0 with credit_o=0;
//   one consumed pulse -> 3rd grant within 1 cycle.
//  T3 issue and consumed in the same cycle at credit=1 -> credit_o stays 1.
//   Extra consumed pulses at credit=MAX_AHEAD -> saturates at 2.
//  T4 frame_start_i pulsed in L_BUSY and DRAIN_HI -> no state or index change.
//   aRst_n low mid-frame -> all outputs at reset values in the same cycle.
//  T5 FRAME_TIMEOUT_EN, TIMEOUT=64, core never sends line_done_i -> timeout_err_o=1 at cycle 64
//   of L_BUSY, state IDLE, no frame_done_o. Without the macro -> stays L_BUSY, timeout_err_o=0.
//  T6 V_line=960, random ack/done/consumed gaps -> 959 grants, alternating line_sel,
//   credit_o in 0..2 throughout, exactly one frame_done_o.

Source files
------------

// File: rtl/interp_line_scheduler_if.sv
// Handshake and status bundle between the line scheduler (master) and the
// interpolation core / AFIFO reader side (slave).
interface interp_line_scheduler_if;
  logic        frame_start_i;
  logic        line_req_o;
  logic        line_ack_i;
  logic        line_sel_o;
  logic [11:0] line_idx_o;
  logic        line_done_i;
  logic        line_consumed_i;
  logic        rd_done_sig;
  logic        frame_busy_o;
  logic        frame_done_o;
  logic [3:0]  credit_o;
  logic        timeout_err_o;

  modport master (
    input  frame_start_i, line_ack_i, line_done_i, line_consumed_i, rd_done_sig,
    output line_req_o, line_sel_o, line_idx_o, frame_busy_o, frame_done_o,
           credit_o, timeout_err_o
  );

  modport slave (
    output frame_start_i, line_ack_i, line_done_i, line_consumed_i, rd_done_sig,
    input  line_req_o, line_sel_o, line_idx_o, frame_busy_o, frame_done_o,
           credit_o, timeout_err_o
  );
endinterface

// File: rtl/interp_line_scheduler.sv
// Frame/line sequencer for the interpolation output path. Grants lines to the
// core alternating ch1/ch0 AFIFOs, meters it with a credit counter so it never
// runs more than MAX_AHEAD lines ahead of the reader, and closes the frame when
// the reader has replayed the last line (rd_done_sig high then low).
// Optional feature: define FRAME_TIMEOUT_EN to enable the L_BUSY watchdog.
module interp_line_scheduler #(
  parameter int unsigned H_pixel   = 1280,
  parameter int unsigned V_line    = 960,
  parameter int unsigned MAX_AHEAD = 2,
  parameter int unsigned TIMEOUT   = 2**20
) (
  input  logic                    Clk,
  input  logic                    aRst_n,
  interp_line_scheduler_if.master sched
);

  localparam logic [3:0]  CREDIT_MAX = 4'(MAX_AHEAD);
  localparam logic [11:0] LAST_IDX   = 12'(V_line - 2);

  // Elaboration-time sanity check of the configuration.
  if (H_pixel == 0 || V_line < 2 || V_line > 4097 ||
      MAX_AHEAD < 1 || MAX_AHEAD > 15 ||
      TIMEOUT < 1 || TIMEOUT > 2**21 - 1) begin : g_param_check
    $error("interp_line_scheduler: parameter out of range");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_L_BUSY,
    S_DRAIN_HI,
    S_DRAIN_LO
  } state_t;

  state_t      state_q, state_d;
  logic        req_q, req_d;
  logic        sel_q, sel_d;
  logic [11:0] idx_q, idx_d;
  logic        busy_q, busy_d;
  logic        fdone_q, fdone_d;
  logic [3:0]  credit_q, credit_d;
  logic        issue;

`ifdef FRAME_TIMEOUT_EN
  logic [20:0] wd_q, wd_d;
  logic        err_q, err_d;
`endif

  // Next-state, credit and registered-output computation.
  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    idx_d    = idx_q;
    credit_d = credit_q;
    fdone_d  = 1'b0;
    issue    = (state_q == S_ISSUE) && req_q && sched.line_ack_i;
`ifdef FRAME_TIMEOUT_EN
    wd_d     = '0;
    err_d    = err_q;
`endif

    // Issue and consume in the same cycle cancel; consume saturates at MAX_AHEAD.
    if (state_q != S_IDLE) begin
      if (issue && !sched.line_consumed_i) begin
        credit_d = credit_q - 4'd1;
      end else if (!issue && sched.line_consumed_i && (credit_q < CREDIT_MAX)) begin
        credit_d = credit_q + 4'd1;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (sched.frame_start_i) begin
          state_d  = S_ISSUE;
          idx_d    = '0;
          sel_d    = 1'b1;
          credit_d = CREDIT_MAX;
        end
      end
      S_ISSUE: begin
        if (issue) state_d = S_L_BUSY;
      end
      S_L_BUSY: begin
        if (sched.line_done_i) begin
          if (idx_q == LAST_IDX) begin
            state_d = S_DRAIN_HI;
          end else begin
            idx_d   = idx_q + 12'd1;
            sel_d   = ~sel_q;
            state_d = S_ISSUE;
          end
        end else begin
`ifdef FRAME_TIMEOUT_EN
          // The TIMEOUT-th consecutive cycle without line_done aborts the frame.
          if (wd_q == 21'(TIMEOUT - 1)) begin
            state_d = S_IDLE;
            err_d   = 1'b1;
          end else begin
            wd_d = wd_q + 21'd1;
          end
`endif
        end
      end
      S_DRAIN_HI: begin
        if (sched.rd_done_sig) state_d = S_DRAIN_LO;
      end
      S_DRAIN_LO: begin
        if (!sched.rd_done_sig) begin
          state_d = S_IDLE;
          fdone_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered, so they are derived from the next state.
    req_d  = (state_d == S_ISSUE) && (credit_d != '0);
    busy_d = (state_d != S_IDLE);
  end

  // State and output registers.
  always_ff @(posedge Clk or negedge aRst_n) begin
    if (!aRst_n) begin
      state_q  <= S_IDLE;
      req_q    <= 1'b0;
      sel_q    <= 1'b1;
      idx_q    <= '0;
      busy_q   <= 1'b0;
      fdone_q  <= 1'b0;
      credit_q <= CREDIT_MAX;
    end else begin
      state_q  <= state_d;
      req_q    <= req_d;
      sel_q    <= sel_d;
      idx_q    <= idx_d;
      busy_q   <= busy_d;
      fdone_q  <= fdone_d;
      credit_q <= credit_d;
    end
  end

`ifdef FRAME_TIMEOUT_EN
  // Watchdog counter and sticky timeout flag.
  always_ff @(posedge Clk or negedge aRst_n) begin
    if (!aRst_n) begin
      wd_q  <= '0;
      err_q <= 1'b0;
    end else begin
      wd_q  <= wd_d;
      err_q <= err_d;
    end
  end

  assign sched.timeout_err_o = err_q;
`else
  assign sched.timeout_err_o = 1'b0;
`endif

  assign sched.line_req_o   = req_q;
  assign sched.line_sel_o   = sel_q;
  assign sched.line_idx_o   = idx_q;
  assign sched.frame_busy_o = busy_q;
  assign sched.frame_done_o = fdone_q;
  assign sched.credit_o     = credit_q;

endmodule

// File: tb/tb_interp_line_scheduler.sv
// Scoreboard bench for interp_line_scheduler: a short-frame instance (V_line=4)
// for directed cases and a full-frame instance (V_line=960) for a long run.
module tb_interp_line_scheduler;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  interp_line_scheduler_if ifa ();
  interp_line_scheduler_if ifb ();

  interp_line_scheduler #(.H_pixel(1280), .V_line(4), .MAX_AHEAD(2), .TIMEOUT(64)) dut_a (
    .Clk(clk), .aRst_n(rst_n), .sched(ifa.master)
  );
  interp_line_scheduler #(.H_pixel(1280), .V_line(960), .MAX_AHEAD(2)) dut_b (
    .Clk(clk), .aRst_n(rst_n), .sched(ifb.master)
  );

  typedef struct packed {
    logic        sel;
    logic [11:0] idx;
  } grant_t;

  grant_t exp_a[$];
  grant_t exp_b[$];
  grant_t ga, gb;
  int checks = 0;
  int failures = 0;
  int fd_a = 0;
  int fd_b = 0;
  int lines_done_b = 0;

  function automatic grant_t mk(input logic sel, input int idx);
    grant_t g;
    g.sel = sel;
    g.idx = 12'(idx);
    return g;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor A: pop expected grant on each req&ack handshake, count frame_done pulses.
  always @(negedge clk) begin
    if (rst_n) begin
      if (ifa.line_req_o && ifa.line_ack_i) begin
        if (exp_a.size() == 0) begin
          check("a_unexpected_grant", 32'd1, 32'd0);
        end else begin
          ga = exp_a.pop_front();
          check("a_grant_sel", 32'(ifa.line_sel_o), 32'(ga.sel));
          check("a_grant_idx", 32'(ifa.line_idx_o), 32'(ga.idx));
        end
      end
      if (ifa.frame_done_o) fd_a++;
    end
  end

  // Monitor B: same scoreboard plus credit range while busy.
  always @(negedge clk) begin
    if (rst_n) begin
      if (ifb.line_req_o && ifb.line_ack_i) begin
        if (exp_b.size() == 0) begin
          check("b_unexpected_grant", 32'd1, 32'd0);
        end else begin
          gb = exp_b.pop_front();
          check("b_grant_sel", 32'(ifb.line_sel_o), 32'(gb.sel));
          check("b_grant_idx", 32'(ifb.line_idx_o), 32'(gb.idx));
        end
      end
      if (ifb.frame_busy_o) check("b_credit_range", 32'(ifb.credit_o <= 4'd2), 32'd1);
      if (ifb.frame_done_o) fd_b++;
    end
  end

  task automatic start_a();
    ifa.frame_start_i = 1'b1;
    tick();
    ifa.frame_start_i = 1'b0;
  endtask

  task automatic ack_a();
    ifa.line_ack_i = 1'b1;
    tick();
    ifa.line_ack_i = 1'b0;
  endtask

  task automatic done_a();
    ifa.line_done_i = 1'b1;
    tick();
    ifa.line_done_i = 1'b0;
  endtask

  task automatic consume_a();
    ifa.line_consumed_i = 1'b1;
    tick();
    ifa.line_consumed_i = 1'b0;
  endtask

  task automatic consume_later_a(input int d);
    fork
      begin
        repeat (d) tick();
        consume_a();
      end
    join_none
  endtask

  task automatic wait_req_a(input string name, input int budget);
    int n = 0;
    while (!ifa.line_req_o && n < budget) begin
      tick();
      n++;
    end
    check(name, 32'(ifa.line_req_o), 32'd1);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_req"},    32'(ifa.line_req_o),    32'd0);
    check({tag, "_sel"},    32'(ifa.line_sel_o),    32'd1);
    check({tag, "_idx"},    32'(ifa.line_idx_o),    32'd0);
    check({tag, "_busy"},   32'(ifa.frame_busy_o),  32'd0);
    check({tag, "_done"},   32'(ifa.frame_done_o),  32'd0);
    check({tag, "_credit"}, 32'(ifa.credit_o),      32'd2);
    check({tag, "_err"},    32'(ifa.timeout_err_o), 32'd0);
  endtask

  task automatic drain_a(input string tag);
    ifa.rd_done_sig = 1'b1;
    repeat (3) tick();
    check({tag, "_drain_busy"}, 32'(ifa.frame_busy_o), 32'd1);
    ifa.rd_done_sig = 1'b0;
    tick();
    check({tag, "_frame_done"}, 32'(ifa.frame_done_o), 32'd1);
    check({tag, "_idle"}, 32'(ifa.frame_busy_o), 32'd0);
    tick();
    check({tag, "_done_pulse"}, 32'(ifa.frame_done_o), 32'd0);
  endtask

  // Global time limit.
  initial begin
    #900000;
    $display("FAIL global_timeout: got running expected finished");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    logic abort_b;
    int consumed_b;
    ifa.frame_start_i = 0; ifa.line_ack_i = 0; ifa.line_done_i = 0;
    ifa.line_consumed_i = 0; ifa.rd_done_sig = 0;
    ifb.frame_start_i = 0; ifb.line_ack_i = 0; ifb.line_done_i = 0;
    ifb.line_consumed_i = 0; ifb.rd_done_sig = 0;
    abort_b = 1'b0;
    consumed_b = 0;

    repeat (2) tick();
    check_reset_vals("reset");
    check("reset_b_credit", 32'(ifb.credit_o), 32'd2);
    rst_n = 1'b1;
    tick();

    // T1: three lines ch1,ch0,ch1; consumption lags 20 cycles behind done.
    exp_a.push_back(mk(1'b1, 0));
    exp_a.push_back(mk(1'b0, 1));
    exp_a.push_back(mk(1'b1, 2));
    start_a();
    check("t1_req_latency", 32'(ifa.line_req_o), 32'd1);
    check("t1_busy", 32'(ifa.frame_busy_o), 32'd1);
    for (int i = 0; i < 3; i++) begin
      wait_req_a("t1_req", 100);
      tick();
      ack_a();
      repeat (4) tick();
      done_a();
      consume_later_a(20);
    end
    check("t1_drain_req", 32'(ifa.line_req_o), 32'd0);
    drain_a("t1");
    repeat (30) tick();
    check("t1_queue_empty", 32'(exp_a.size()), 32'd0);
    check("t1_frames", 32'(fd_a), 32'd1);

    // T2: no consumption -> two grants, then stall at credit 0.
    exp_a.push_back(mk(1'b1, 0));
    exp_a.push_back(mk(1'b0, 1));
    exp_a.push_back(mk(1'b1, 2));
    start_a();
    check("t2_credit_start", 32'(ifa.credit_o), 32'd2);
    wait_req_a("t2_req0", 10);
    ack_a();
    check("t2_credit_after_1", 32'(ifa.credit_o), 32'd1);
    repeat (2) tick();
    done_a();
    check("t2_req1_latency", 32'(ifa.line_req_o), 32'd1);
    ack_a();
    check("t2_credit_after_2", 32'(ifa.credit_o), 32'd0);
    done_a();
    repeat (10) tick();
    check("t2_stall_req", 32'(ifa.line_req_o), 32'd0);
    check("t2_stall_credit", 32'(ifa.credit_o), 32'd0);
    check("t2_stall_idx", 32'(ifa.line_idx_o), 32'd2);
    check("t2_stall_sel", 32'(ifa.line_sel_o), 32'd1);
    consume_a();
    check("t2_third_grant", 32'(ifa.line_req_o), 32'd1);
    check("t2_credit_1", 32'(ifa.credit_o), 32'd1);

    // T3: issue and consume together, then saturation.
    ifa.line_ack_i = 1'b1;
    ifa.line_consumed_i = 1'b1;
    tick();
    ifa.line_ack_i = 1'b0;
    ifa.line_consumed_i = 1'b0;
    check("t3_issue_and_consume", 32'(ifa.credit_o), 32'd1);
    check("t3_req_dropped", 32'(ifa.line_req_o), 32'd0);
    repeat (3) consume_a();
    check("t3_saturate", 32'(ifa.credit_o), 32'd2);
    done_a();

    // T4: frame_start in DRAIN_HI is dropped.
    start_a();
    check("t4_drain_busy", 32'(ifa.frame_busy_o), 32'd1);
    check("t4_drain_idx", 32'(ifa.line_idx_o), 32'd2);
    check("t4_drain_req", 32'(ifa.line_req_o), 32'd0);
    drain_a("t4");
    check("t4_frames", 32'(fd_a), 32'd2);

    // T4/T5: frame_start in L_BUSY, then a line that never completes.
    exp_a.push_back(mk(1'b1, 0));
    start_a();
    wait_req_a("t5_req0", 10);
    ack_a();
    start_a();
    check("t4_lbusy_busy", 32'(ifa.frame_busy_o), 32'd1);
    check("t4_lbusy_idx", 32'(ifa.line_idx_o), 32'd0);
    check("t4_lbusy_sel", 32'(ifa.line_sel_o), 32'd1);
    check("t4_lbusy_req", 32'(ifa.line_req_o), 32'd0);
    repeat (62) tick();
    check("t5_before_busy", 32'(ifa.frame_busy_o), 32'd1);
    check("t5_before_err", 32'(ifa.timeout_err_o), 32'd0);
    tick();
`ifdef FRAME_TIMEOUT_EN
    check("t5_timeout_busy", 32'(ifa.frame_busy_o), 32'd0);
    check("t5_timeout_err", 32'(ifa.timeout_err_o), 32'd1);
`else
    check("t5_no_timeout_busy", 32'(ifa.frame_busy_o), 32'd1);
    check("t5_no_timeout_err", 32'(ifa.timeout_err_o), 32'd0);
`endif
    check("t5_req", 32'(ifa.line_req_o), 32'd0);
    repeat (3) tick();
    check("t5_no_frame_done", 32'(fd_a), 32'd2);

    // Asynchronous reset mid-frame takes effect before the next edge.
    rst_n = 1'b0;
    #2;
    check_reset_vals("t4_async_reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    check("t4_queue_empty", 32'(exp_a.size()), 32'd0);

    // T6: full frame with random gaps.
    for (int i = 0; i < 959; i++) exp_b.push_back(mk(i[0] ? 1'b0 : 1'b1, i));
    ifb.frame_start_i = 1'b1;
    tick();
    ifb.frame_start_i = 1'b0;
    fork
      begin
        for (int i = 0; i < 959 && !abort_b; i++) begin
          int n = 0;
          while (!ifb.line_req_o && n < 200) begin
            tick();
            n++;
          end
          if (!ifb.line_req_o) begin
            check("b_req_timeout", 32'(ifb.line_req_o), 32'd1);
            abort_b = 1'b1;
          end else begin
            repeat ($urandom_range(0, 3)) tick();
            ifb.line_ack_i = 1'b1;
            tick();
            ifb.line_ack_i = 1'b0;
            repeat ($urandom_range(1, 6)) tick();
            ifb.line_done_i = 1'b1;
            tick();
            ifb.line_done_i = 1'b0;
            lines_done_b++;
          end
        end
      end
      begin
        int guard = 0;
        while (consumed_b < 959 && !abort_b && guard < 40000) begin
          tick();
          guard++;
          if (consumed_b < lines_done_b) begin
            repeat ($urandom_range(0, 4)) tick();
            ifb.line_consumed_i = 1'b1;
            tick();
            ifb.line_consumed_i = 1'b0;
            consumed_b++;
          end
        end
      end
    join
    check("b_lines_done", 32'(lines_done_b), 32'd959);
    check("b_all_consumed", 32'(consumed_b), 32'd959);
    check("b_drain_busy", 32'(ifb.frame_busy_o), 32'd1);
    ifb.rd_done_sig = 1'b1;
    repeat (2) tick();
    ifb.rd_done_sig = 1'b0;
    tick();
    check("b_frame_done", 32'(ifb.frame_done_o), 32'd1);
    repeat (3) tick();
    check("b_frames", 32'(fd_b), 32'd1);
    check("b_queue_empty", 32'(exp_b.size()), 32'd0);
    check("b_idle", 32'(ifb.frame_busy_o), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
